prf_scoreboard_mp: RTL and testbench

- Parametrised multi-port physical register file with an integrated ready-bit scoreboard.
- Keeps a bank of NUM_CKPT ready-table snapshots. Snapshots are live-updated by writebacks and restored on branch mispredict.
- Sits between rename/dispatch (alloc, ready queries) and the functional units (operand reads, writeback, wakeup broadcast).
- Supersedes the fixed 3-FU register file: port counts become generic, and it adds same-cycle bypass, checkpoint save-by-id and registered wakeup.

---
 rtl/prf_scoreboard_mp_pkg.sv | 15 +
 rtl/prf_scoreboard_mp_if.sv | 39 +++
 rtl/prf_scoreboard_mp_ckpt_bank.sv | 22 ++
 rtl/prf_scoreboard_mp.sv | 74 +++++++
 tb/tb_prf_scoreboard_mp.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prf_scoreboard_mp_pkg.sv
// prf_scoreboard_mp_pkg: default sizing and shared types for the multi-port register file scoreboard
package prf_scoreboard_mp_pkg;
  localparam int DEF_NUM_PREGS = 128;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NUM_RD = 6;
  localparam int DEF_NUM_WR = 3;
  localparam int DEF_NUM_Q = 6;
  localparam int DEF_NUM_ALLOC = 3;
  localparam int DEF_NUM_CKPT = 4;
  localparam int PREG_W = $clog2(DEF_NUM_PREGS);
  localparam int CKPT_W = $clog2(DEF_NUM_CKPT);
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [DEF_NUM_PREGS-1:0] rdy_vec_t;
  typedef logic [CKPT_W-1:0] ckpt_t;
endpackage

// File: rtl/prf_scoreboard_mp_if.sv
// prf_scoreboard_mp_if: rename/FU-facing bus of the register file scoreboard
interface prf_scoreboard_mp_if import prf_scoreboard_mp_pkg::*; #(
  parameter int NUM_PREGS = DEF_NUM_PREGS,
  parameter int XLEN = DEF_XLEN,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR,
  parameter int NUM_Q = DEF_NUM_Q,
  parameter int NUM_ALLOC = DEF_NUM_ALLOC,
  parameter int NUM_CKPT = DEF_NUM_CKPT
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(NUM_CKPT);
  logic [NUM_RD-1:0][PW-1:0] rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_WR-1:0] wr_en;
  logic [NUM_WR-1:0][PW-1:0] wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data;
  logic [NUM_WR-1:0] wake_valid;
  logic [NUM_WR-1:0][PW-1:0] wake_tag;
  logic [NUM_Q-1:0][PW-1:0] q_addr;
  logic [NUM_Q-1:0] q_rdy;
  logic [NUM_ALLOC-1:0] alloc_en;
  logic [NUM_ALLOC-1:0][PW-1:0] alloc_addr;
  logic ckpt_save;
  logic [CW-1:0] ckpt_save_id;
  logic flush;
  logic [CW-1:0] flush_id;
  logic [NUM_PREGS-1:0] rdy_table;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, q_addr, alloc_en, alloc_addr,
           ckpt_save, ckpt_save_id, flush, flush_id,
    input rd_data, wake_valid, wake_tag, q_rdy, rdy_table
  );
  modport slave (
    input rd_addr, wr_en, wr_addr, wr_data, q_addr, alloc_en, alloc_addr,
          ckpt_save, ckpt_save_id, flush, flush_id,
    output rd_data, wake_valid, wake_tag, q_rdy, rdy_table
  );
endinterface

// File: rtl/prf_scoreboard_mp_ckpt_bank.sv
// prf_scoreboard_mp_ckpt_bank: ready-table snapshot slots, live-updated by writebacks
module prf_scoreboard_mp_ckpt_bank #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_CKPT = 4,
  parameter int CW = $clog2(NUM_CKPT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_save,
  input  logic [CW-1:0]        i_save_id,
  input  logic [NUM_PREGS-1:0] i_save_val,
  input  logic [NUM_PREGS-1:0] i_wmask,
  input  logic [CW-1:0]        i_sel_id,
  output logic [NUM_PREGS-1:0] o_sel
);
  logic [NUM_PREGS-1:0] r_slot [NUM_CKPT];
  // slots not being saved absorb writebacks so older in-flight results survive a restore
  always_ff @(posedge clk)
    for (int s = 0; s < NUM_CKPT; s++)
      r_slot[s] <= !reset ? '1 : (i_save && i_save_id == CW'(s)) ? i_save_val : r_slot[s] | i_wmask;
  assign o_sel = r_slot[i_sel_id];
endmodule

// File: rtl/prf_scoreboard_mp.sv
// prf_scoreboard_mp: multi-port physical register file with bypassed reads,
// ready-bit scoreboard, checkpoint snapshots and registered wakeup
module prf_scoreboard_mp import prf_scoreboard_mp_pkg::*; #(
  parameter int NUM_PREGS = DEF_NUM_PREGS,
  parameter int XLEN = DEF_XLEN,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR,
  parameter int NUM_Q = DEF_NUM_Q,
  parameter int NUM_ALLOC = DEF_NUM_ALLOC,
  parameter int NUM_CKPT = DEF_NUM_CKPT
) (
  input logic clk,
  input logic reset,
  prf_scoreboard_mp_if.slave bus
);
  localparam int PW = $clog2(NUM_PREGS);
  logic [XLEN-1:0] r_regs [NUM_PREGS];
  logic [NUM_PREGS-1:0] r_rdy, w_wmask, w_amask, w_live_next, w_slot_sel;
  logic [NUM_WR-1:0] r_wake_valid;
  logic [NUM_WR-1:0][PW-1:0] r_wake_tag;
  always_comb begin
    w_wmask = '0;
    w_amask = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (bus.wr_en[j] && bus.wr_addr[j] != '0) w_wmask[bus.wr_addr[j]] = 1'b1;
    for (int a = 0; a < NUM_ALLOC; a++)
      if (bus.alloc_en[a] && bus.alloc_addr[a] != '0) w_amask[bus.alloc_addr[a]] = 1'b1;
  end
  // alloc beats a same-cycle write on the ready bit
  assign w_live_next = (r_rdy | w_wmask) & ~w_amask;
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i] = bus.rd_addr[i] == '0 ? '0 : r_regs[bus.rd_addr[i]];
      for (int j = 0; j < NUM_WR; j++)
        if (bus.wr_en[j] && bus.rd_addr[i] != '0 && bus.wr_addr[j] == bus.rd_addr[i]) bus.rd_data[i] = bus.wr_data[j];
    end
  end
  always_comb
    for (int k = 0; k < NUM_Q; k++)
      bus.q_rdy[k] = bus.q_addr[k] == '0 || r_rdy[bus.q_addr[k]] || w_wmask[bus.q_addr[k]];
  prf_scoreboard_mp_ckpt_bank #(.NUM_PREGS(NUM_PREGS), .NUM_CKPT(NUM_CKPT)) u_bank (
    .clk        (clk),
    .reset      (reset),
    .i_save     (bus.ckpt_save && !bus.flush),
    .i_save_id  (bus.ckpt_save_id),
    .i_save_val (w_live_next),
    .i_wmask    (w_wmask),
    .i_sel_id   (bus.flush_id),
    .o_sel      (w_slot_sel)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PREGS; p++) r_regs[p] <= '0;
      r_rdy <= '1;
      r_wake_valid <= '0;
      r_wake_tag <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (bus.wr_en[j] && bus.wr_addr[j] != '0) r_regs[bus.wr_addr[j]] <= bus.wr_data[j];
      r_rdy <= bus.flush ? w_slot_sel | w_wmask : w_live_next;
      for (int j = 0; j < NUM_WR; j++) r_wake_valid[j] <= bus.wr_en[j] && bus.wr_addr[j] != '0;
      r_wake_tag <= bus.wr_addr;
    end
  end
  // two writeback ports targeting one live tag in the same cycle is a producer bug
  always_ff @(posedge clk)
    if (reset)
      for (int j = 0; j < NUM_WR; j++)
        for (int k = j + 1; k < NUM_WR; k++)
          assert (!(bus.wr_en[j] && bus.wr_en[k] && bus.wr_addr[j] != '0 && bus.wr_addr[j] == bus.wr_addr[k]));
  assign bus.wake_valid = r_wake_valid;
  assign bus.wake_tag = r_wake_tag;
  assign bus.rdy_table = r_rdy;
endmodule

// File: tb/tb_prf_scoreboard_mp.sv
// tb_prf_scoreboard_mp: directed plan plus random traffic against an array-based reference model
module tb_prf_scoreboard_mp;
  import prf_scoreboard_mp_pkg::*;
  localparam int NP = 128, XL = 32, NR = 6, NW = 3, NQ = 6, NA = 3, NC = 4, PW = 7;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  prf_scoreboard_mp_if #(.NUM_PREGS(NP), .XLEN(XL), .NUM_RD(NR), .NUM_WR(NW), .NUM_Q(NQ),
    .NUM_ALLOC(NA), .NUM_CKPT(NC)) bus ();
  prf_scoreboard_mp #(.NUM_PREGS(NP), .XLEN(XL), .NUM_RD(NR), .NUM_WR(NW), .NUM_Q(NQ),
    .NUM_ALLOC(NA), .NUM_CKPT(NC)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [XL-1:0] m_regs [NP];
  bit m_rdy [NP];
  bit m_slot [NC][NP];
  logic [NW-1:0] m_wv;
  preg_t m_wt [NW];
  task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [XL-1:0] m_read(input preg_t a);
    logic [XL-1:0] v = (a == 0) ? '0 : m_regs[a];
    for (int j = 0; j < NW; j++) if (bus.wr_en[j] && a != 0 && bus.wr_addr[j] == a) v = bus.wr_data[j];
    return v;
  endfunction
  function automatic bit m_query(input preg_t a);
    bit r = (a == 0) || m_rdy[a];
    for (int j = 0; j < NW; j++) if (bus.wr_en[j] && bus.wr_addr[j] == a) r = 1'b1;
    return r;
  endfunction
  task automatic idle();
    bus.wr_en = '0;
    bus.alloc_en = '0;
    bus.ckpt_save = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic wr(input int p, input preg_t a, input logic [XL-1:0] d);
    bus.wr_en[p] = 1'b1;
    bus.wr_addr[p] = a;
    bus.wr_data[p] = d;
  endtask
  task automatic al(input int p, input preg_t a);
    bus.alloc_en[p] = 1'b1;
    bus.alloc_addr[p] = a;
  endtask
  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      chk($sformatf("rd_data[%0d] addr %0d", i, bus.rd_addr[i]), bus.rd_data[i], m_read(bus.rd_addr[i]));
    for (int k = 0; k < NQ; k++)
      chk($sformatf("q_rdy[%0d] addr %0d", k, bus.q_addr[k]), bus.q_rdy[k], m_query(bus.q_addr[k]));
  endtask
  task automatic tick();
    bit w [NP];
    bit a [NP];
    bit nr [NP];
    logic [NP-1:0] mv;
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        m_regs[p] = '0;
        m_rdy[p] = 1'b1;
        for (int s = 0; s < NC; s++) m_slot[s][p] = 1'b1;
      end
      m_wv = '0;
      for (int j = 0; j < NW; j++) m_wt[j] = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        w[p] = 1'b0;
        a[p] = 1'b0;
      end
      for (int j = 0; j < NW; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j] != 0) begin
          w[bus.wr_addr[j]] = 1'b1;
          m_regs[bus.wr_addr[j]] = bus.wr_data[j];
        end
        m_wv[j] = bus.wr_en[j] && bus.wr_addr[j] != 0;
        m_wt[j] = bus.wr_addr[j];
      end
      for (int k = 0; k < NA; k++) if (bus.alloc_en[k] && bus.alloc_addr[k] != 0) a[bus.alloc_addr[k]] = 1'b1;
      for (int p = 0; p < NP; p++)
        nr[p] = bus.flush ? (m_slot[bus.flush_id][p] | w[p]) : ((m_rdy[p] | w[p]) & !a[p]);
      for (int s = 0; s < NC; s++)
        for (int p = 0; p < NP; p++)
          m_slot[s][p] = (!bus.flush && bus.ckpt_save && int'(bus.ckpt_save_id) == s) ? nr[p] : (m_slot[s][p] | w[p]);
      for (int p = 0; p < NP; p++) m_rdy[p] = nr[p];
    end
    for (int p = 0; p < NP; p++) mv[p] = m_rdy[p];
    chk("rdy_table", bus.rdy_table, mv);
    chk("wake_valid", bus.wake_valid, m_wv);
    for (int j = 0; j < NW; j++) chk($sformatf("wake_tag[%0d]", j), bus.wake_tag[j], m_wt[j]);
  endtask
  task automatic cycle();
    settle();
    tick();
  endtask
  function automatic preg_t pick();
    return ($urandom_range(0, 3) == 0) ? preg_t'($urandom_range(0, NP - 1)) : preg_t'($urandom_range(0, 15));
  endfunction
  initial begin
    bus.rd_addr = '0;
    bus.q_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.alloc_addr = '0;
    bus.ckpt_save_id = '0;
    bus.flush_id = '0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) bus.rd_addr[i] = 7'd5;
    for (int k = 0; k < NQ; k++) bus.q_addr[k] = 7'd5;
    settle();
    chk("reset rd P5", bus.rd_data[0], 0);
    chk("reset q P5", bus.q_rdy[0], 1);
    chk("reset wake", bus.wake_valid, 0);
    tick();
    al(0, 7'd10);
    cycle();
    idle();
    bus.q_addr[0] = 7'd10;
    settle();
    chk("q P10 after alloc", bus.q_rdy[0], 0);
    tick();
    cycle();
    wr(1, 7'd10, 32'hDEADBEEF);
    bus.rd_addr[0] = 7'd10;
    settle();
    chk("bypass rd P10", bus.rd_data[0], 32'hDEADBEEF);
    chk("bypass q P10", bus.q_rdy[0], 1);
    tick();
    chk("wake P10 valid", bus.wake_valid, 3'b010);
    chk("wake P10 tag", bus.wake_tag[1], 10);
    idle();
    cycle();
    chk("wake P10 pulse", bus.wake_valid, 0);
    al(0, 7'd20);
    bus.ckpt_save = 1'b1;
    bus.ckpt_save_id = 2'd2;
    cycle();
    idle();
    al(0, 7'd21);
    cycle();
    idle();
    wr(0, 7'd20, 32'h20);
    cycle();
    idle();
    cycle();
    bus.flush = 1'b1;
    bus.flush_id = 2'd2;
    al(0, 7'd50);
    cycle();
    chk("flush2 P20 live", bus.rdy_table[20], 1);
    chk("flush2 P21 restored", bus.rdy_table[21], 1);
    chk("flush2 P50 alloc ignored", bus.rdy_table[50], 1);
    idle();
    wr(2, 7'd30, 32'h5555AAAA);
    al(1, 7'd30);
    cycle();
    chk("wr+alloc P30 rdy", bus.rdy_table[30], 0);
    idle();
    bus.rd_addr[1] = 7'd30;
    bus.q_addr[1] = 7'd30;
    settle();
    chk("wr+alloc P30 data", bus.rd_data[1], 32'h5555AAAA);
    chk("wr+alloc P30 q", bus.q_rdy[1], 0);
    tick();
    wr(0, 7'd0, 32'h1234);
    bus.rd_addr[2] = 7'd0;
    settle();
    chk("P0 rd", bus.rd_data[2], 0);
    tick();
    chk("P0 no wake", bus.wake_valid[0], 0);
    idle();
    al(0, 7'd40);
    al(1, 7'd41);
    bus.ckpt_save = 1'b1;
    bus.ckpt_save_id = 2'd1;
    cycle();
    idle();
    al(0, 7'd42);
    cycle();
    idle();
    bus.flush = 1'b1;
    bus.flush_id = 2'd1;
    bus.ckpt_save = 1'b1;
    bus.ckpt_save_id = 2'd1;
    wr(0, 7'd40, 32'h40);
    al(0, 7'd43);
    cycle();
    chk("flush1 P40", bus.rdy_table[40], 1);
    chk("flush1 P41", bus.rdy_table[41], 0);
    chk("flush1 P42", bus.rdy_table[42], 1);
    chk("flush1 P43", bus.rdy_table[43], 1);
    idle();
    al(0, 7'd42);
    cycle();
    idle();
    bus.flush = 1'b1;
    bus.flush_id = 2'd1;
    cycle();
    chk("slot1 kept P42", bus.rdy_table[42], 1);
    chk("slot1 kept P43", bus.rdy_table[43], 1);
    chk("slot1 kept P41", bus.rdy_table[41], 0);
    idle();
    al(0, 7'd60);
    bus.ckpt_save = 1'b1;
    bus.ckpt_save_id = 2'd3;
    cycle();
    idle();
    al(0, 7'd61);
    al(1, 7'd62);
    wr(0, 7'd63, 32'h63);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    idle();
    chk("midreset rdy", bus.rdy_table, '1);
    chk("midreset wake", bus.wake_valid, 0);
    for (int s = 0; s < NC; s++) begin
      idle();
      bus.flush = 1'b1;
      bus.flush_id = 2'(s);
      cycle();
      chk($sformatf("midreset slot%0d", s), bus.rdy_table, '1);
    end
    for (int c = 0; c < 500; c++) begin
      idle();
      for (int j = 0; j < NW; j++) begin
        bus.wr_addr[j] = pick();
        bus.wr_data[j] = $urandom;
        bus.wr_en[j] = $urandom_range(0, 1) == 1;
        for (int k = 0; k < j; k++) if (bus.wr_en[k] && bus.wr_addr[k] == bus.wr_addr[j]) bus.wr_en[j] = 1'b0;
      end
      for (int k = 0; k < NA; k++) begin
        bus.alloc_addr[k] = pick();
        bus.alloc_en[k] = $urandom_range(0, 2) == 0;
      end
      for (int i = 0; i < NR; i++) bus.rd_addr[i] = pick();
      for (int k = 0; k < NQ; k++) bus.q_addr[k] = pick();
      bus.ckpt_save = $urandom_range(0, 7) == 0;
      bus.ckpt_save_id = 2'($urandom_range(0, NC - 1));
      bus.flush = $urandom_range(0, 9) == 0;
      bus.flush_id = 2'($urandom_range(0, NC - 1));
      reset = $urandom_range(0, 99) != 0;
      cycle();
    end
    reset = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
